// File: rtl/rvarb_pkg.sv
// Shared types and helpers for the rvarb round-robin lock arbiter family.
// Used by rvarb_rr_pick and rvarb_rr_lock.
package rvarb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int unsigned RVARB_TMO_DEF = 15;
  localparam int unsigned RVARB_MAXREQ  = 16;

  // Reference round-robin pick: first set bit scanning ptr, ptr+1, ... modulo n.
  function automatic logic [RVARB_MAXREQ-1:0] rr_pick(
    input logic [RVARB_MAXREQ-1:0] req,
    input logic [3:0]              ptr,
    input int unsigned             n
  );
    logic [RVARB_MAXREQ-1:0] win;
    logic                    found;
    int unsigned             idx;
    win   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < RVARB_MAXREQ; k++) begin
      idx = (n == 0) ? 0 : (32'(ptr) + k) % n;
      if (k < n && !found && req[idx[3:0]]) begin
        win[idx[3:0]] = 1'b1;
        found         = 1'b1;
      end
    end
    return win;
  endfunction

  function automatic logic [3:0] oh2bin(input logic [RVARB_MAXREQ-1:0] oh);
    logic [3:0] b;
    b = '0;
    for (int unsigned k = 0; k < RVARB_MAXREQ; k++) begin
      if (oh[k]) b = b | k[3:0];
    end
    return b;
  endfunction

endpackage

// File: rtl/rvarb_rr_pick.sv
// Combinational round-robin picker: rotate requests by ptr, isolate the lowest
// set bit, rotate back. Yields a one-hot winner (or zero) plus an any-request flag.
module rvarb_rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] win,
  output logic            any
);

  logic [NREQ-1:0] rot;
  logic [NREQ-1:0] lsb;

  always_comb begin
    // Double-width concatenation turns the modular rotation into a plain shift.
    rot = NREQ'({req, req} >> ptr);
    lsb = rot & (~rot + NREQ'(1));
    win = NREQ'(({lsb, lsb} << ptr) >> NREQ);
    any = |req;
  end

endmodule

// File: rtl/rvarb_rr_lock.sv
// Round-robin arbiter with burst lock for a shared registered resource.
// Optional idle-owner timeout enabled by defining RVARB_RR_LOCK_TMO_EN.
module rvarb_rr_lock
  import rvarb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2,
  parameter int unsigned TMO  = RVARB_TMO_DEF
) (
  input  logic            clk,
  input  logic            rst_l,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] req_last,
  input  logic            rdy,
  output logic [NREQ-1:0] gnt,
  output logic            gnt_vld,
  output logic [IDW-1:0]  gnt_id,
  output logic            xfer,
  output logic            rel,
  output logic            tmo_err
);

  if (IDW != $clog2(NREQ)) begin : g_bad_idw
    $error("IDW must equal clog2(NREQ)");
  end
  if (NREQ < 2 || NREQ > RVARB_MAXREQ) begin : g_bad_nreq
    $error("NREQ out of range 2..16");
  end
  if (TMO < 1) begin : g_bad_tmo
    $error("TMO must be at least 1");
  end

  arb_state_e      state, state_nxt;
  logic [NREQ-1:0] gnt_nxt;
  logic            gnt_vld_nxt;
  logic [IDW-1:0]  gnt_id_nxt;
  logic [IDW-1:0]  ptr, ptr_nxt, ptr_sel, id_inc;
  logic [NREQ-1:0] pick_win;
  logic            pick_any;
  logic            own_req;
  logic            force_rel;
  logic            release_any;

  assign own_req     = req[gnt_id];
  assign xfer        = gnt_vld & own_req & rdy;
  assign rel         = xfer & req_last[gnt_id];
  assign release_any = rel | force_rel;
  assign id_inc      = (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + IDW'(1);

  // On release the picker already sees the advanced pointer, so the handoff is bubble-free.
  assign ptr_sel = (state == BUSY && release_any) ? id_inc : ptr;

  rvarb_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req (req),
    .ptr (ptr_sel),
    .win (pick_win),
    .any (pick_any)
  );

  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    gnt_vld_nxt = gnt_vld;
    gnt_id_nxt  = gnt_id;
    ptr_nxt     = ptr;
    case (state)
      IDLE: begin
        if (pick_any) begin
          gnt_nxt     = pick_win;
          gnt_vld_nxt = 1'b1;
          gnt_id_nxt  = IDW'(oh2bin(RVARB_MAXREQ'(pick_win)));
          state_nxt   = BUSY;
        end
      end
      BUSY: begin
        if (release_any) begin
          ptr_nxt = id_inc;
          if (pick_any) begin
            gnt_nxt     = pick_win;
            gnt_vld_nxt = 1'b1;
            gnt_id_nxt  = IDW'(oh2bin(RVARB_MAXREQ'(pick_win)));
          end else begin
            gnt_nxt     = '0;
            gnt_vld_nxt = 1'b0;
            gnt_id_nxt  = '0;
            state_nxt   = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state   <= IDLE;
      gnt     <= '0;
      gnt_vld <= 1'b0;
      gnt_id  <= '0;
      ptr     <= '0;
    end else begin
      state   <= state_nxt;
      gnt     <= gnt_nxt;
      gnt_vld <= gnt_vld_nxt;
      gnt_id  <= gnt_id_nxt;
      ptr     <= ptr_nxt;
    end
  end

`ifdef RVARB_RR_LOCK_TMO_EN
  localparam int unsigned CW = ($clog2(TMO + 1) > 4) ? $clog2(TMO + 1) : 4;

  logic [CW-1:0] tmo_cnt;

  // Count reaching TMO forces the release in the following cycle, flagged by tmo_err.
  assign force_rel = (state == BUSY) && (tmo_cnt == CW'(TMO));
  assign tmo_err   = force_rel;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      tmo_cnt <= '0;
    end else if (state == BUSY) begin
      if (release_any || own_req) tmo_cnt <= '0;
      else                        tmo_cnt <= tmo_cnt + CW'(1);
    end else begin
      tmo_cnt <= '0;
    end
  end
`else
  assign force_rel = 1'b0;
  assign tmo_err   = 1'b0;
`endif

endmodule

// File: tb/tb_rvarb_rr_lock.sv
// Bench for rvarb_rr_lock: directed vector table, hand-written corner sequences,
// and randomized traffic against a scan-based reference model.
module tb_rvarb_rr_lock;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;
  localparam int unsigned TMO  = 15;

  logic            clk = 1'b0;
  logic            rst_l;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] req_last;
  logic            rdy;
  logic [NREQ-1:0] gnt;
  logic            gnt_vld;
  logic [IDW-1:0]  gnt_id;
  logic            xfer;
  logic            rel;
  logic            tmo_err;

  always #5 clk = ~clk;

  rvarb_rr_lock #(
    .NREQ (NREQ),
    .IDW  (IDW),
    .TMO  (TMO)
  ) dut (
    .clk      (clk),
    .rst_l    (rst_l),
    .req      (req),
    .req_last (req_last),
    .rdy      (rdy),
    .gnt      (gnt),
    .gnt_vld  (gnt_vld),
    .gnt_id   (gnt_id),
    .xfer     (xfer),
    .rel      (rel),
    .tmo_err  (tmo_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0] req;
    logic [3:0] last;
    logic       rdy;
    logic [3:0] gnt;
    logic       xfer;
    logic       rel;
  } vec_t;

  vec_t vt[17];

  function automatic int idx_of(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return 0;
  endfunction

  // Reference model: owner index (-1 when free), priority pointer, idle-owner count.
  int m_own, m_ptr, m_cnt;

  function automatic int scan(input logic [3:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (p + k) % NREQ;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic m_tmo();
`ifdef RVARB_RR_LOCK_TMO_EN
    return (m_own >= 0) && (m_cnt >= TMO);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic m_xfer();
    if (m_own < 0) return 1'b0;
    return req[m_own] && rdy;
  endfunction

  task automatic model_check();
    logic [3:0] eg;
    logic       ex, er;
    eg = (m_own >= 0) ? 4'(1 << m_own) : 4'b0000;
    ex = m_xfer();
    er = ex && req_last[m_own];
    chk("rnd_gnt",     32'(gnt),     32'(eg));
    chk("rnd_gnt_vld", 32'(gnt_vld), 32'(eg != 0));
    chk("rnd_gnt_id",  32'(gnt_id),  (m_own >= 0) ? 32'(m_own) : 32'd0);
    chk("rnd_xfer",    32'(xfer),    32'(ex));
    chk("rnd_rel",     32'(rel),     32'(er));
    chk("rnd_tmo_err", 32'(tmo_err), 32'(m_tmo()));
  endtask

  task automatic model_edge();
    logic r;
    if (m_own < 0) begin
      m_own = scan(req, m_ptr);
    end else begin
      r = m_xfer() && req_last[m_own];
      if (r || m_tmo()) begin
        m_ptr = (m_own + 1) % NREQ;
        m_cnt = 0;
        m_own = scan(req, m_ptr);
      end else if (req[m_own]) begin
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // req, last, rdy, expected gnt (registered), xfer, rel
    vt[0]  = '{4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0};
    vt[1]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b1};
    vt[2]  = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 1'b1};
    vt[3]  = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 1'b1};
    vt[4]  = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 1'b1};
    vt[5]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b1};
    vt[6]  = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 1'b1};
    vt[7]  = '{4'b0101, 4'b0000, 1'b1, 4'b0100, 1'b1, 1'b0};
    vt[8]  = '{4'b0101, 4'b0000, 1'b0, 4'b0100, 1'b0, 1'b0};
    vt[9]  = '{4'b0101, 4'b0000, 1'b1, 4'b0100, 1'b1, 1'b0};
    vt[10] = '{4'b0101, 4'b0100, 1'b1, 4'b0100, 1'b1, 1'b1};
    vt[11] = '{4'b0101, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b1};
    vt[12] = '{4'b1100, 4'b0100, 1'b1, 4'b0100, 1'b1, 1'b1};
    vt[13] = '{4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b1, 1'b1};
    vt[14] = '{4'b1000, 4'b0000, 1'b0, 4'b1000, 1'b0, 1'b0};
    vt[15] = '{4'b1011, 4'b1011, 1'b1, 4'b1000, 1'b1, 1'b1};
    vt[16] = '{4'b0000, 4'b0001, 1'b1, 4'b0001, 1'b0, 1'b0};

    rst_l    = 1'b0;
    req      = 4'b1111;
    req_last = 4'b1111;
    rdy      = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_gnt",     32'(gnt),     32'd0);
      chk("rst_gnt_vld", 32'(gnt_vld), 32'd0);
      chk("rst_gnt_id",  32'(gnt_id),  32'd0);
      chk("rst_tmo_err", 32'(tmo_err), 32'd0);
    end
    tick();
    rst_l = 1'b1;

    for (int i = 0; i < 17; i++) begin
      req      = vt[i].req;
      req_last = vt[i].last;
      rdy      = vt[i].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d_gnt", i),     32'(gnt),     32'(vt[i].gnt));
      chk($sformatf("vec%0d_gnt_vld", i), 32'(gnt_vld), 32'(vt[i].gnt != 0));
      chk($sformatf("vec%0d_gnt_id", i),  32'(gnt_id),  32'(idx_of(vt[i].gnt)));
      chk($sformatf("vec%0d_xfer", i),    32'(xfer),    32'(vt[i].xfer));
      chk($sformatf("vec%0d_rel", i),     32'(rel),     32'(vt[i].rel));
      tick();
    end

    // Asynchronous reset in the middle of owner 1's burst.
    rst_l    = 1'b0;
    req      = 4'b0010;
    req_last = 4'b0000;
    rdy      = 1'b1;
    #20;
    tick();
    rst_l = 1'b1;
    tick();
    @(negedge clk);
    chk("async_pre_gnt",    32'(gnt),    32'h2);
    chk("async_pre_gnt_id", 32'(gnt_id), 32'd1);
    @(posedge clk);
    #3;
    rst_l = 1'b0;
    #1;
    chk("async_gnt",     32'(gnt),     32'd0);
    chk("async_gnt_vld", 32'(gnt_vld), 32'd0);
    chk("async_gnt_id",  32'(gnt_id),  32'd0);
    #20;
    tick();
    rst_l = 1'b1;

    // Owner 1 abandons its burst while requester 3 waits.
    tick();
    @(negedge clk);
    chk("tmo_own_gnt", 32'(gnt), 32'h2);
    tick();
    req = 4'b1000;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      chk($sformatf("tmo_hold%0d_gnt", k), 32'(gnt),     32'h2);
      chk($sformatf("tmo_hold%0d_err", k), 32'(tmo_err), 32'd0);
      tick();
    end
`ifdef RVARB_RR_LOCK_TMO_EN
    @(negedge clk);
    chk("tmo_pulse_err", 32'(tmo_err), 32'd1);
    chk("tmo_pulse_gnt", 32'(gnt),     32'h2);
    tick();
    @(negedge clk);
    chk("tmo_after_gnt", 32'(gnt),     32'h8);
    chk("tmo_after_err", 32'(tmo_err), 32'd0);
    tick();
`else
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("lock_persist_gnt", 32'(gnt),     32'h2);
      chk("lock_persist_err", 32'(tmo_err), 32'd0);
      tick();
    end
`endif

    // Randomized traffic against the reference model.
    rst_l = 1'b0;
    req   = '0;
    #20;
    tick();
    rst_l = 1'b1;
    m_own = -1;
    m_ptr = 0;
    m_cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      req = 4'($urandom_range(0, 15));
      if (m_own >= 0 && $urandom_range(0, 99) < 97) req[m_own] = 1'b1;
      req_last = 4'($urandom) & 4'($urandom);
      rdy      = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      model_check();
      @(posedge clk);
      model_edge();
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
